// File: rtl/iommu.sv
// IOMMU/IOPMP shared types.
package iommu;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    WR_PREV,
    WR_CUR,
    RESP
  } iopmp_enc_state_e;

endpackage

// File: rtl/riscv.sv
// RISC-V privileged-spec types shared by the PMP/IOPMP logic.
package riscv;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    TOR   = 2'd1,
    NA4   = 2'd2,
    NAPOT = 2'd3
  } pmp_addr_mode_t;

endpackage

// File: rtl/lzc.sv
// Leading/trailing zero counter: MODE=0 counts trailing zeros, MODE=1 leading zeros.
// empty_o flags an all-zero input (cnt_o is then 0).
module lzc #(
  parameter int unsigned WIDTH     = 2,
  parameter bit          MODE      = 1'b0,
  parameter int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0]     in_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 empty_o
);

  always_comb begin
    cnt_o   = '0;
    empty_o = ~|in_i;
    if (MODE) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (in_i[i]) cnt_o = CNT_WIDTH'(int'(WIDTH) - 1 - i);
      end
    end else begin
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
        if (in_i[i]) cnt_o = CNT_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/iopmp_region_encoder.sv
// Encodes a byte region [base, top) into NA4/NAPOT/TOR pmpaddr writes for one IOPMP entry.
// One request in flight; write port and response both honour back-pressure.
module iopmp_region_encoder
  import riscv::*;
  import iommu::*;
#(
  parameter int unsigned PLEN           = 56,
  parameter int unsigned PMP_LEN        = 54,
  parameter int unsigned PMPGranularity = 2,
  parameter int unsigned NR_ENTRIES     = 16,
  parameter int unsigned IDX_W          = $clog2(NR_ENTRIES)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [PLEN-1:0]    req_base_i,
  input  logic [PLEN-1:0]    req_top_i,
  input  logic [IDX_W-1:0]   req_idx_i,
  output logic               wr_valid_o,
  input  logic               wr_ready_i,
  output logic [IDX_W-1:0]   wr_idx_o,
  output logic [PMP_LEN-1:0] wr_addr_o,
  output pmp_addr_mode_t     wr_mode_o,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic               rsp_err_o,
  output pmp_addr_mode_t     rsp_mode_o
);

  localparam int unsigned     CNT_W     = $clog2(PLEN);
  localparam logic [PLEN-1:0] GRAN      = PLEN'(1) << PMPGranularity;
  localparam logic [PLEN-1:0] GRAN_MASK = GRAN - PLEN'(1);

  iopmp_enc_state_e   state_q, state_d;
  logic [PLEN-1:0]    base_q, base_d, top_q, top_d;
  logic [IDX_W-1:0]   idx_q, idx_d, wr_idx_q, wr_idx_d;
  logic [PMP_LEN-1:0] wr_addr_q, wr_addr_d;
  pmp_addr_mode_t     wr_mode_q, wr_mode_d, rsp_mode_q, rsp_mode_d;
  logic               rsp_err_q, rsp_err_d;

  logic [PLEN-1:0]    len;
  logic [CNT_W-1:0]   len_tz;
  logic               len_zero, is_na4, is_napot, is_err;
  logic [PMP_LEN-1:0] base_pa, top_pa, napot_mask;

  assign len     = top_q - base_q;
  assign base_pa = PMP_LEN'(base_q >> 2);
  assign top_pa  = PMP_LEN'(top_q >> 2);

  // For a power-of-two length the trailing-zero count is log2(len).
  lzc #(.WIDTH(PLEN), .MODE(1'b0)) u_len_lzc (
    .in_i   (len),
    .cnt_o  (len_tz),
    .empty_o(len_zero)
  );

  assign napot_mask = (PMP_LEN'(1) << (len_tz - CNT_W'(3))) - PMP_LEN'(1);
  assign is_na4     = (len == PLEN'(4)) && (PMPGranularity <= 2);
  assign is_napot   = ((len & (len - PLEN'(1))) == '0) && (len >= PLEN'(8)) &&
                      (len >= GRAN) && ((base_q & (len - PLEN'(1))) == '0);

  // A TOR pair needs entry idx-1 for the lower bound, so idx 0 can only take NA4/NAPOT.
  assign is_err = len_zero || (top_q <= base_q) || (((base_q | top_q) & GRAN_MASK) != '0) ||
                  ((top_q >> (PMP_LEN + 2)) != '0) || (32'(idx_q) >= NR_ENTRIES) ||
                  (!is_na4 && !is_napot && (idx_q == '0));

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    top_d       = top_q;
    idx_d       = idx_q;
    wr_idx_d    = wr_idx_q;
    wr_addr_d   = wr_addr_q;
    wr_mode_d   = wr_mode_q;
    rsp_err_d   = rsp_err_q;
    rsp_mode_d  = rsp_mode_q;
    req_ready_o = 1'b0;
    wr_valid_o  = 1'b0;
    rsp_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          base_d  = req_base_i;
          top_d   = req_top_i;
          idx_d   = req_idx_i;
          state_d = CHECK;
        end
      end
      CHECK: begin
        rsp_err_d = 1'b0;
        wr_idx_d  = idx_q;
        wr_addr_d = base_pa;
        if (is_err) begin
          rsp_err_d  = 1'b1;
          rsp_mode_d = OFF;
          state_d    = RESP;
        end else if (is_na4) begin
          wr_mode_d  = NA4;
          rsp_mode_d = NA4;
          state_d    = WR_CUR;
        end else if (is_napot) begin
          wr_addr_d  = base_pa | napot_mask;
          wr_mode_d  = NAPOT;
          rsp_mode_d = NAPOT;
          state_d    = WR_CUR;
        end else begin
          wr_idx_d   = idx_q - IDX_W'(1);
          wr_mode_d  = OFF;
          rsp_mode_d = TOR;
          state_d    = WR_PREV;
        end
      end
      WR_PREV: begin
        wr_valid_o = 1'b1;
        if (wr_ready_i) begin
          wr_idx_d  = idx_q;
          wr_addr_d = top_pa;
          wr_mode_d = TOR;
          state_d   = WR_CUR;
        end
      end
      WR_CUR: begin
        wr_valid_o = 1'b1;
        if (wr_ready_i) state_d = RESP;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      base_q     <= '0;
      top_q      <= '0;
      idx_q      <= '0;
      wr_idx_q   <= '0;
      wr_addr_q  <= '0;
      wr_mode_q  <= OFF;
      rsp_err_q  <= 1'b0;
      rsp_mode_q <= OFF;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      top_q      <= top_d;
      idx_q      <= idx_d;
      wr_idx_q   <= wr_idx_d;
      wr_addr_q  <= wr_addr_d;
      wr_mode_q  <= wr_mode_d;
      rsp_err_q  <= rsp_err_d;
      rsp_mode_q <= rsp_mode_d;
    end
  end

  assign wr_idx_o   = wr_idx_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_mode_o  = wr_mode_q;
  assign rsp_err_o  = rsp_err_q;
  assign rsp_mode_o = rsp_mode_q;

endmodule

// File: tb/tb_iopmp_region_encoder.sv
// Scoreboard bench for iopmp_region_encoder (default G=2 instance plus a G=3 instance).
module tb_iopmp_region_encoder;
  import riscv::*;

  typedef struct packed {
    logic [3:0]     idx;
    logic [53:0]    addr;
    pmp_addr_mode_t mode;
  } wr_t;
  typedef struct packed {
    logic           err;
    pmp_addr_mode_t mode;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic req_valid, req_ready, wr_valid, wr_ready, rsp_valid, rsp_ready, rsp_err;
  logic [55:0] req_base, req_top;
  logic [3:0]  req_idx, wr_idx;
  logic [53:0] wr_addr;
  pmp_addr_mode_t wr_mode, rsp_mode;

  logic g3_req_valid, g3_req_ready, g3_wr_valid, g3_wr_ready, g3_rsp_valid, g3_rsp_ready, g3_rsp_err;
  logic [3:0]  g3_wr_idx;
  logic [53:0] g3_wr_addr;
  pmp_addr_mode_t g3_wr_mode, g3_rsp_mode;

  wr_t  exp_wr_q[$], obs_wr_q[$];
  rsp_t exp_rsp_q[$], obs_rsp_q[$];
  int   wr_seen, g3_wr_seen;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  iopmp_region_encoder dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_base_i(req_base), .req_top_i(req_top), .req_idx_i(req_idx),
    .wr_valid_o(wr_valid), .wr_ready_i(wr_ready),
    .wr_idx_o(wr_idx), .wr_addr_o(wr_addr), .wr_mode_o(wr_mode),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_err_o(rsp_err), .rsp_mode_o(rsp_mode)
  );

  iopmp_region_encoder #(.PMPGranularity(3)) dut_g3 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(g3_req_valid), .req_ready_o(g3_req_ready),
    .req_base_i(req_base), .req_top_i(req_top), .req_idx_i(req_idx),
    .wr_valid_o(g3_wr_valid), .wr_ready_i(g3_wr_ready),
    .wr_idx_o(g3_wr_idx), .wr_addr_o(g3_wr_addr), .wr_mode_o(g3_wr_mode),
    .rsp_valid_o(g3_rsp_valid), .rsp_ready_i(g3_rsp_ready),
    .rsp_err_o(g3_rsp_err), .rsp_mode_o(g3_rsp_mode)
  );

  // Handshakes are observed mid-cycle; inputs only change just after posedge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_valid) wr_seen++;
      if (g3_wr_valid) g3_wr_seen++;
      if (wr_valid && wr_ready) obs_wr_q.push_back(wr_t'({wr_idx, wr_addr, wr_mode}));
      if (rsp_valid && rsp_ready) obs_rsp_q.push_back(rsp_t'({rsp_err, rsp_mode}));
    end
  end

  task automatic clear_sb();
    exp_wr_q.delete(); obs_wr_q.delete(); exp_rsp_q.delete(); obs_rsp_q.delete();
    wr_seen = 0; g3_wr_seen = 0;
  endtask

  // Issues one request; lat is the cycle (handshake cycle = 0) in which rsp_valid is seen, -1 on timeout.
  // Request inputs are scrambled after acceptance since the DUT must use its latched copy.
  task automatic send_req(input logic [55:0] b, input logic [55:0] t, input logic [3:0] i, output int lat);
    int c;
    req_base = b; req_top = t; req_idx = i; req_valid = 1'b1;
    lat = -1;
    c = 0;
    @(negedge clk);
    while (!req_ready && c < 40) begin @(negedge clk); c++; end
    if (req_ready) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_base = 56'({$urandom(), $urandom()});
      req_top  = 56'({$urandom(), $urandom()});
      req_idx  = 4'($urandom());
      c = 0;
      while (c < 40) begin @(negedge clk); c++; if (rsp_valid) break; end
      if (rsp_valid) lat = c;
      @(posedge clk); #1;
    end else begin
      req_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({req_ready, wr_valid, rsp_valid, rsp_err} !== 4'b1000) begin
      tests_failed++; $display("FAIL reset_ctrl: got %b expected 1000", {req_ready, wr_valid, rsp_valid, rsp_err});
    end
    tests_run++;
    if ({wr_idx, wr_addr} !== 58'd0) begin
      tests_failed++; $display("FAIL reset_wr: got idx=%h addr=%h expected 0", wr_idx, wr_addr);
    end
    tests_run++;
    if ({wr_mode, rsp_mode} !== {OFF, OFF}) begin
      tests_failed++; $display("FAIL reset_mode: got %0d/%0d expected OFF/OFF", wr_mode, rsp_mode);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++; $display("FAIL reset_idle_ready: got %b expected 1", req_ready);
    end
  endtask

  task automatic test_napot();
    logic [55:0] bases [3] = '{56'h8000_0000, 56'h0, 56'h40_0000_0000};
    logic [55:0] tops  [3] = '{56'h8000_1000, 56'h8, 56'h80_0000_0000};
    logic [3:0]  idxs  [3] = '{4'd3, 4'd0, 4'd15};
    logic [53:0] addrs [3] = '{54'h2000_01FF, 54'h0, 54'h17_FFFF_FFFF};
    int lat;
    for (int k = 0; k < 3; k++) begin
      clear_sb();
      exp_wr_q.push_back('{idxs[k], addrs[k], NAPOT});
      exp_rsp_q.push_back('{1'b0, NAPOT});
      send_req(bases[k], tops[k], idxs[k], lat);
      tests_run++;
      if (lat !== 3) begin tests_failed++; $display("FAIL napot%0d_latency: got %0d expected 3", k, lat); end
      tests_run++;
      if (obs_wr_q.size() != 1 || obs_wr_q[0] !== exp_wr_q[0]) begin
        tests_failed++; $display("FAIL napot%0d_write: got %0d writes first=%h expected %h", k, obs_wr_q.size(),
                                 (obs_wr_q.size() > 0) ? obs_wr_q[0] : wr_t'(0), exp_wr_q[0]);
      end
      tests_run++;
      if (obs_rsp_q.size() != 1 || obs_rsp_q[0] !== exp_rsp_q[0]) begin
        tests_failed++; $display("FAIL napot%0d_rsp: got %0d rsps expected %h", k, obs_rsp_q.size(), exp_rsp_q[0]);
      end
    end
  endtask

  task automatic test_na4();
    int lat, c;
    clear_sb();
    exp_wr_q.push_back('{4'd0, 54'h401, NA4});
    exp_rsp_q.push_back('{1'b0, NA4});
    send_req(56'h1004, 56'h1008, 4'd0, lat);
    tests_run++;
    if (lat !== 3) begin tests_failed++; $display("FAIL na4_latency: got %0d expected 3", lat); end
    tests_run++;
    if (obs_wr_q.size() != 1 || obs_wr_q[0] !== exp_wr_q[0]) begin
      tests_failed++; $display("FAIL na4_write: got %0d writes expected one of %h", obs_wr_q.size(), exp_wr_q[0]);
    end
    tests_run++;
    if (obs_rsp_q.size() != 1 || obs_rsp_q[0] !== exp_rsp_q[0]) begin
      tests_failed++; $display("FAIL na4_rsp: got %0d rsps expected %h", obs_rsp_q.size(), exp_rsp_q[0]);
    end
    // The same 4-byte region is below the 8-byte granule of the G=3 instance.
    clear_sb();
    req_base = 56'h1004; req_top = 56'h1008; req_idx = 4'd0; g3_req_valid = 1'b1;
    c = 0;
    @(negedge clk);
    while (!g3_req_ready && c < 20) begin @(negedge clk); c++; end
    @(posedge clk); #1;
    g3_req_valid = 1'b0;
    c = 0;
    while (c < 20) begin @(negedge clk); c++; if (g3_rsp_valid) break; end
    tests_run++;
    if (g3_rsp_valid !== 1'b1 || c !== 2) begin
      tests_failed++; $display("FAIL na4_g3_latency: valid=%b after %0d cycles expected 1 after 2", g3_rsp_valid, c);
    end
    tests_run++;
    if ({g3_rsp_err, g3_rsp_mode} !== {1'b1, OFF} || g3_wr_seen != 0) begin
      tests_failed++; $display("FAIL na4_g3_err: got err=%b mode=%0d writes=%0d expected 1/OFF/0",
                               g3_rsp_err, g3_rsp_mode, g3_wr_seen);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_tor();
    int lat;
    clear_sb();
    exp_wr_q.push_back('{4'd4, 54'h400, OFF});
    exp_wr_q.push_back('{4'd5, 54'h700, TOR});
    send_req(56'h1000, 56'h1C00, 4'd5, lat);
    tests_run++;
    if (lat !== 4) begin tests_failed++; $display("FAIL tor_latency: got %0d expected 4", lat); end
    tests_run++;
    if (obs_wr_q.size() != 2) begin
      tests_failed++; $display("FAIL tor_write_count: got %0d expected 2", obs_wr_q.size());
    end
    for (int k = 0; k < 2 && k < obs_wr_q.size(); k++) begin
      tests_run++;
      if (obs_wr_q[k] !== exp_wr_q[k]) begin
        tests_failed++; $display("FAIL tor_write%0d: got %h expected %h", k, obs_wr_q[k], exp_wr_q[k]);
      end
    end
    tests_run++;
    if (obs_rsp_q.size() != 1 || obs_rsp_q[0] !== rsp_t'({1'b0, TOR})) begin
      tests_failed++; $display("FAIL tor_rsp: got %0d rsps expected err=0 mode=TOR", obs_rsp_q.size());
    end
    clear_sb();
    send_req(56'h1000, 56'h1C00, 4'd0, lat);
    tests_run++;
    if (lat !== 2 || wr_seen != 0 || obs_rsp_q.size() != 1 || obs_rsp_q[0] !== rsp_t'({1'b1, OFF})) begin
      tests_failed++; $display("FAIL tor_idx0: got lat=%0d writes=%0d rsps=%0d expected 2/0/1 err OFF",
                               lat, wr_seen, obs_rsp_q.size());
    end
  endtask

  task automatic test_errors();
    logic [55:0] bases [5] = '{56'h2000, 56'h1002, 56'h3000, 56'h0, 56'h1000};
    logic [55:0] tops  [5] = '{56'h2000, 56'h2000, 56'h2000, 56'h0, 56'h1003};
    int lat;
    for (int k = 0; k < 5; k++) begin
      clear_sb();
      send_req(bases[k], tops[k], 4'd1, lat);
      tests_run++;
      if (lat !== 2) begin tests_failed++; $display("FAIL err%0d_latency: got %0d expected 2", k, lat); end
      tests_run++;
      if (wr_seen != 0 || obs_rsp_q.size() != 1 || obs_rsp_q[0] !== rsp_t'({1'b1, OFF})) begin
        tests_failed++; $display("FAIL err%0d_rsp: got writes=%0d rsps=%0d first=%h expected 0/1/%h", k, wr_seen,
                                 obs_rsp_q.size(), (obs_rsp_q.size() > 0) ? obs_rsp_q[0] : rsp_t'(0), rsp_t'({1'b1, OFF}));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [55:0] bases [3] = '{56'h1004, 56'h1000, 56'h2000};
    logic [55:0] tops  [3] = '{56'h1008, 56'h1C00, 56'h2100};
    logic [3:0]  idxs  [3] = '{4'd7, 4'd9, 4'd2};
    int lat;
    clear_sb();
    exp_wr_q.push_back('{4'd7, 54'h401, NA4});
    exp_wr_q.push_back('{4'd8, 54'h400, OFF});
    exp_wr_q.push_back('{4'd9, 54'h700, TOR});
    exp_wr_q.push_back('{4'd2, 54'h81F, NAPOT});
    for (int k = 0; k < 3; k++) begin
      send_req(bases[k], tops[k], idxs[k], lat);
      tests_run++;
      if (req_ready !== 1'b1 || lat < 0) begin
        tests_failed++; $display("FAIL b2b%0d_ready: got ready=%b lat=%0d expected ready=1", k, req_ready, lat);
      end
    end
    tests_run++;
    if (obs_wr_q.size() != 4) begin
      tests_failed++; $display("FAIL b2b_write_count: got %0d expected 4", obs_wr_q.size());
    end
    for (int k = 0; k < 4 && k < obs_wr_q.size(); k++) begin
      tests_run++;
      if (obs_wr_q[k] !== exp_wr_q[k]) begin
        tests_failed++; $display("FAIL b2b_write%0d: got %h expected %h", k, obs_wr_q[k], exp_wr_q[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    int c;
    int lat;
    clear_sb();
    exp_wr_q.push_back('{4'd4, 54'h400, OFF});
    exp_wr_q.push_back('{4'd5, 54'h700, TOR});
    wr_ready = 1'b0;
    req_base = 56'h1000; req_top = 56'h1C00; req_idx = 4'd5; req_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    req_valid = 1'b0; req_base = 56'hFFF0; req_idx = 4'd1;
    c = 0;
    do begin @(negedge clk); c++; end while (!wr_valid && c < 20);
    for (int k = 0; k < 5; k++) begin
      tests_run++;
      if ({wr_valid, req_ready, wr_idx, wr_addr, wr_mode} !== {1'b1, 1'b0, exp_wr_q[0]}) begin
        tests_failed++; $display("FAIL bp_hold%0d: got v=%b rdy=%b %h expected v=1 rdy=0 %h",
                                 k, wr_valid, req_ready, {wr_idx, wr_addr, wr_mode}, exp_wr_q[0]);
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    wr_ready = 1'b1;
    c = 0;
    while (!rsp_valid && c < 20) begin @(negedge clk); c++; end
    @(posedge clk); #1;
    tests_run++;
    if (obs_wr_q.size() != 2 || obs_wr_q[0] !== exp_wr_q[0] || obs_wr_q[1] !== exp_wr_q[1]) begin
      tests_failed++; $display("FAIL bp_writes: got %0d writes expected %h then %h", obs_wr_q.size(), exp_wr_q[0], exp_wr_q[1]);
    end
    clear_sb();
    rsp_ready = 1'b0;
    send_req(56'h8000_0000, 56'h8000_1000, 4'd3, lat);
    for (int k = 0; k < 5; k++) begin
      tests_run++;
      if ({rsp_valid, rsp_err, rsp_mode} !== {1'b1, 1'b0, NAPOT}) begin
        tests_failed++; $display("FAIL bp_rsp_hold%0d: got v=%b err=%b mode=%0d expected 1/0/NAPOT",
                                 k, rsp_valid, rsp_err, rsp_mode);
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || obs_rsp_q.size() != 1) begin
      tests_failed++; $display("FAIL bp_rsp_release: got v=%b rdy=%b rsps=%0d expected 0/1/1",
                               rsp_valid, req_ready, obs_rsp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    clear_sb();
    req_base = 56'h1000; req_top = 56'h1C00; req_idx = 4'd5; req_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({wr_valid, wr_idx} !== {1'b1, 4'd5}) begin
      tests_failed++; $display("FAIL rstmid_in_cur: got v=%b idx=%0d expected 1/5", wr_valid, wr_idx);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if ({req_ready, wr_valid, rsp_valid, rsp_err, wr_idx, wr_addr, wr_mode, rsp_mode} !== {4'b1000, 58'd0, OFF, OFF}) begin
      tests_failed++; $display("FAIL rstmid_values: got rdy=%b v=%b rv=%b err=%b idx=%h addr=%h expected reset values",
                               req_ready, wr_valid, rsp_valid, rsp_err, wr_idx, wr_addr);
    end
    tests_run++;
    if (obs_wr_q.size() != 1 || obs_wr_q[0] !== wr_t'({4'd4, 54'h400, OFF})) begin
      tests_failed++; $display("FAIL rstmid_prev_only: got %0d writes expected only idx4", obs_wr_q.size());
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    clear_sb();
    send_req(56'h8000_0000, 56'h8000_1000, 4'd3, lat);
    tests_run++;
    if (lat !== 3 || obs_wr_q.size() != 1 || obs_wr_q[0] !== wr_t'({4'd3, 54'h2000_01FF, NAPOT})) begin
      tests_failed++; $display("FAIL rstmid_after: got lat=%0d writes=%0d expected 3/1 NAPOT", lat, obs_wr_q.size());
    end
  endtask

  initial begin
    req_valid = 1'b0; req_base = '0; req_top = '0; req_idx = '0;
    wr_ready = 1'b1; rsp_ready = 1'b1;
    g3_req_valid = 1'b0; g3_wr_ready = 1'b1; g3_rsp_ready = 1'b1;
    wr_seen = 0; g3_wr_seen = 0;
    test_reset();
    test_napot();
    test_na4();
    test_tor();
    test_errors();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
